// File: rtl/division_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// widths, the controller state encoding and a sizing helper for the bit counter.
package division_pkg;

   localparam int DEF_DIVIDEND_W = 32;
   localparam int DEF_DIVISOR_W  = 16;

   // Controller states: waiting, iterating, presenting a result for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the iteration counter: it must hold values up to w-1 with a
   // spare bit so the terminal compare never wraps.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor and subtract when it fits.
module div_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] rem_i,      // partial remainder, always < divisor
   input  logic         bit_i,      // next dividend bit, MSB first
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_o,      // updated partial remainder
   output logic         q_bit_o     // quotient bit produced by this step
);

   logic [W:0] shifted;
   logic       fits;

   // Compare-and-subtract on the W+1-bit shifted remainder. When the divisor
   // fits, the true difference is below the divisor, so a W-bit modular
   // subtraction of the low bits gives the exact result.
   always_comb begin
      shifted = {rem_i, bit_i};
      fits    = (shifted >= {1'b0, divisor_i});
      q_bit_o = fits;
      rem_o   = fits ? (shifted[W-1:0] - divisor_i) : shifted[W-1:0];
   end

endmodule

// File: rtl/division_main.sv
// Sequential unsigned divider: one quotient bit per clock, MSB first, with a
// one-cycle done pulse, divide-by-zero shortcut and held result registers.
module division_main
   import division_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int              CNT_W    = cnt_width(DIVIDEND_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

   state_t                  state_q, state_d;
   // Dividend shift register: the MSB feeds the step each cycle and the new
   // quotient bit enters at the LSB, so after DIVIDEND_W steps it holds the quotient.
   logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]    dsr_q, dsr_d;     // captured divisor
   logic [DIVISOR_W-1:0]    prem_q, prem_d;   // running partial remainder
   logic [CNT_W-1:0]        cnt_q, cnt_d;     // iterations completed
   logic [DIVIDEND_W-1:0]   quo_q, quo_d;     // result registers, held between DONEs
   logic [DIVISOR_W-1:0]    rem_q, rem_d;
   logic                    dbz_q, dbz_d;

   logic [DIVISOR_W-1:0]    step_rem;
   logic                    step_qbit;
   logic [DIVIDEND_W-1:0]   dvd_shift;
   logic                    accept;

   div_step #(
      .W (DIVISOR_W)
   ) u_step (
      .rem_i     (prem_q),
      .bit_i     (dvd_q[DIVIDEND_W-1]),
      .divisor_i (dsr_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_qbit)
   );

   assign dvd_shift = {dvd_q[DIVIDEND_W-2:0], step_qbit};

   // A new request is only honoured when no operation is in flight.
   assign accept = start && ((state_q == IDLE) || (state_q == DONE));

   // Next-state and datapath control; every register defaults to holding.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               dvd_d   = dividend;
               dsr_d   = divisor;
               prem_d  = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         BUSY: begin
            if (dsr_q == '0) begin
               // No iterations for a zero divisor: saturate the quotient and
               // pass the low dividend bits through as the remainder.
               quo_d   = '1;
               rem_d   = dvd_q[DIVISOR_W-1:0];
               dbz_d   = 1'b1;
               state_d = DONE;
            end else begin
               dvd_d  = dvd_shift;
               prem_d = step_rem;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  quo_d   = dvd_shift;
                  rem_d   = step_rem;
                  dbz_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and wins over start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == BUSY);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division_main.sv
// Scoreboard bench for division_main: the driver pushes the arithmetic
// reference result for every accepted request, the monitor pops on done.
module tb_division_main;

   localparam int DW = 32;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [SW-1:0] divisor = '0;
   logic          busy, done, div_by_zero;
   logic [DW-1:0] quotient;
   logic [SW-1:0] remainder;

   division_main #(
      .DIVIDEND_W (DW),
      .DIVISOR_W  (SW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic          dbz;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain integer division; zero divisor saturates.
   function automatic exp_t model(input logic [DW-1:0] a, input logic [SW-1:0] b, input int k);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 0) begin
         e.q   = '1;
         e.r   = a[SW-1:0];
         e.dbz = 1'b1;
         e.due = k + 1;
      end else begin
         e.q   = a / DW'(b);
         e.r   = SW'(a % DW'(b));
         e.dbz = 1'b0;
         e.due = k + DW;
      end
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %h / %h -> q=%h r=%h dbz=%0d at cycle %0d",
                     e.a, e.b, quotient, remainder, div_by_zero, cyc);
            check("quotient", 64'(quotient), 64'(e.q));
            check("remainder", 64'(remainder), 64'(e.r));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            check("latency", 64'(cyc), 64'(e.due));
         end
      end
   end

   // Issue one request as soon as the DUT can take it; returns #1 after the accepting edge.
   task automatic issue(input logic [DW-1:0] a, input logic [SW-1:0] b);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got busy=1 expected idle within 200 cycles");
      end
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = SW'($urandom);
      sb.push_back(model(a, b, cyc));
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   // Wait until every pushed expectation has been consumed.
   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy || done) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0 || busy) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_done_timeout: got done=0 expected done within 100 cycles");
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_quotient"}, 64'(quotient), 64'd0);
      check({tag, "_remainder"}, 64'(remainder), 64'd0);
      check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      logic [DW-1:0] prev_q;
      logic [SW-1:0] prev_r;
      int            d0;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      // Reset has priority over a simultaneous start.
      start = 1'b1;
      dividend = 32'd100;
      divisor = 16'd7;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      check("rst_over_start_busy", 64'(busy), 64'd0);
      repeat (2) @(posedge clk);
      #1;

      // Directed cases.
      issue(32'h0000C350, 16'h00FA);
      drain();
      issue(32'hFFFE0001, 16'hFFFF);
      issue(32'd100, 16'd7);
      issue(32'd5, 16'd9);
      drain();
      issue(32'h12345678, 16'h0000);
      issue(32'd10, 16'd3);
      drain();

      // Start during BUSY is ignored; exactly one done results.
      d0 = n_done;
      issue(32'd1000, 16'd33);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      dividend = 32'd77;
      divisor = 16'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain();
      repeat (40) @(posedge clk);
      #1;
      check("single_done_pulse", 64'(n_done - d0), 64'd1);

      // Reset in the middle of an operation.
      issue($urandom, 16'd1234);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      check_all_zero("midreset");
      issue(32'd100, 16'd7);
      drain();

      // Back-to-back: start held during the DONE cycle.
      issue(32'd123456, 16'd789);
      wait_done();
      prev_q = quotient;
      prev_r = remainder;
      issue(32'hDEADBEEF, 16'h0101);
      check("b2b_hold_q", 64'(quotient), 64'(32'd123456 / 32'd789));
      check("b2b_hold_r", 64'(remainder), 64'(32'd123456 % 32'd789));
      repeat (15) @(posedge clk);
      #1;
      check("b2b_mid_hold_q", 64'(quotient), 64'(prev_q));
      check("b2b_mid_hold_r", 64'(remainder), 64'(prev_r));
      drain();

      // Randomised traffic with small, zero and large divisors.
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = '0;
            1: b = SW'($urandom_range(1, 15));
            2: begin b = SW'($urandom); a = DW'($urandom_range(0, 65535)); end
            default: b = SW'($urandom);
         endcase
         issue(a, b);
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();
      repeat (5) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/division_main.md
DIVISION_MAIN -- requirements
Module: division_main

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 32, dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 16, divisor and remainder width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request a division; sampled only when busy=0.
REQ-006 SHALL have port dividend, input, DIVIDEND_W, unsigned numerator; captured with start.
REQ-007 SHALL have port divisor, input, DIVISOR_W, unsigned denominator; captured with start.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when results are valid.
REQ-010 SHALL have port quotient, output, DIVIDEND_W, unsigned quotient.
REQ-011 SHALL have port remainder, output, DIVISOR_W, unsigned remainder.
REQ-012 SHALL have port div_by_zero, output, 1, high with done when the divisor was 0.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL accept start in IDLE or DONE, capture both operands, and enter BUSY on the same edge.
REQ-015 SHALL ignore start while in BUSY; the operation in flight SHALL NOT be disturbed.
REQ-016 SHALL in BUSY perform restoring division, one quotient bit per clock, MSB first, using a DIVISOR_W+1-bit partial remainder.
REQ-017 SHALL with start sampled at edge k and a nonzero divisor, enter DONE at edge k+DIVIDEND_W (k+32 by default), with busy high over cycles k..k+31.
REQ-018 SHALL hold done high for exactly one cycle, in the DONE state, then go to IDLE unless start is high.
REQ-019 SHALL update quotient, remainder and div_by_zero only on entry to DONE, and hold them until the next DONE or reset.
REQ-020 SHALL guarantee dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-021 SHALL on divisor=0 skip the iterations and enter DONE at edge k+1 with quotient all ones, remainder = dividend[DIVISOR_W-1:0] and div_by_zero=1.
REQ-022 SHALL clear div_by_zero on every DONE entry whose divisor is nonzero.
REQ-023 SHALL when dividend < divisor return quotient 0 and remainder = dividend, with full latency.
REQ-024 SHALL let the operands change freely after capture without affecting the result.

Reset
REQ-025 SHALL on rst=1 at any edge, including mid-BUSY, go to IDLE and zero busy, done, quotient, remainder, div_by_zero and all internal registers.
REQ-026 SHALL give rst priority over start when both are high on the same edge; that start is discarded.

Structure
REQ-027 SHALL place the default widths and the FSM state encoding (IDLE/BUSY/DONE) in shared package division_pkg.
REQ-028 SHALL isolate one combinational compare-and-subtract iteration in sub-module div_step, instantiated once.
REQ-029 SHALL use a bit counter of clog2(DIVIDEND_W)+1 bits, with no inferred multipliers or dividers.

Verification
REQ-030 SHALL cover this scenario: start with 0x0000C350 / 0x00FA -> done at cycle 32 after start, quotient 0x000000C8, remainder 0x0000, div_by_zero 0.
REQ-031 SHALL cover this scenario: 0xFFFE0001 / 0xFFFF -> quotient 0x0000FFFF, remainder 0x0000; also 100/7 -> quotient 14, remainder 2; also 5/9 -> quotient 0, remainder 5.
REQ-032 SHALL cover this scenario: 0x12345678 / 0x0000 -> done one cycle after start, quotient 0xFFFFFFFF, remainder 0x5678, div_by_zero 1; the next 10/3 SHALL give div_by_zero 0.
REQ-033 SHALL cover this scenario: a second start with different operands pulsed at cycle 5 of BUSY -> ignored; the first result is unchanged and there is exactly one done pulse.
REQ-034 SHALL cover this scenario: rst asserted at cycle 10 of BUSY -> next cycle busy=0, all outputs 0, no done; a following 100/7 completes correctly.
REQ-035 SHALL cover this scenario: start held high during the DONE cycle -> the new operation starts back-to-back, busy rises immediately, and the prior outputs hold until the new DONE.
